// File: rtl/axi_rd_arbiter_pkg.sv
// Shared read-side AXI constants and the AR request record used by the read arbiter.
package axi_rd_arbiter_pkg;

  localparam logic [3:0] INST_ID_DEF    = 4'd0;
  localparam logic [3:0] DATA_ID_DEF    = 4'd1;

  localparam logic [3:0] AXI_LEN_SINGLE = 4'd0;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_LOCK_NORM  = 2'b00;
  localparam logic [3:0] AXI_CACHE_NONE = 4'b0000;
  localparam logic [2:0] AXI_PROT_NONE  = 3'b000;

  localparam logic [1:0] SRAM_SIZE_BYTE = 2'd0;
  localparam logic [1:0] SRAM_SIZE_HALF = 2'd1;
  localparam logic [1:0] SRAM_SIZE_WORD = 2'd2;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [2:0]  size;
  } ar_req_t;

  // sram-like size is already log2(bytes), so AXI size is a zero-extension
  function automatic logic [2:0] axi_size(input logic [1:0] sram_size);
    return {1'b0, sram_size};
  endfunction

endpackage

// File: rtl/axi_rd_arbiter_outstanding.sv
// Saturating in-flight read counter for one requester; decrement is ignored when
// empty so stray R beats cannot wrap it.
module rd_outstanding_cnt #(
  parameter  int MAX = 2,
  localparam int W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         full,
  output logic         empty
);

  logic inc_ok;
  logic dec_ok;

  assign full   = (cnt == W'(MAX));
  assign empty  = (cnt == '0);
  assign inc_ok = inc && !full;
  assign dec_ok = dec && !empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (inc_ok && !dec_ok) begin
      cnt <= cnt + W'(1);
    end else if (dec_ok && !inc_ok) begin
      cnt <= cnt - W'(1);
    end
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI AR/R channel pair between instruction-fetch and data-load
// requesters: data-first arbitration with starvation relief, RAW blocking, ID routing.
module axi_rd_arbiter
  import axi_rd_arbiter_pkg::*;
#(
  parameter logic [3:0] INST_ID         = INST_ID_DEF,
  parameter logic [3:0] DATA_ID         = DATA_ID_DEF,
  parameter int         MAX_OUTSTANDING = 2,
  parameter int         STARVE_LIM      = 4
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        inst_req,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,

  input  logic        wr_busy,
  input  logic [31:0] wr_addr,

  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,

  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        rready
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int SW = $clog2(STARVE_LIM + 1);

  logic          slot_free;
  logic          raw_hit;
  logic          inst_elig;
  logic          data_elig;
  logic          starved;
  logic          inst_gnt;
  logic          data_gnt;
  logic          inst_hit;
  logic          data_hit;
  logic [CW-1:0] inst_cnt;
  logic [CW-1:0] data_cnt;
  logic          inst_full;
  logic          data_full;
  logic          inst_empty;
  logic          data_empty;
  logic [SW-1:0] starve_cnt;
  ar_req_t       ar_q;
  ar_req_t       ar_next;

  // Byte lanes never matter for RAW: any overlap in the same word blocks the read.
  logic          addr_lsb_unused;
  logic          cnt_empty_unused;

  assign addr_lsb_unused  = ^wr_addr[1:0];
  assign cnt_empty_unused = inst_empty & data_empty;

  assign slot_free = !arvalid || arready;
  assign raw_hit   = wr_busy && (wr_addr[31:2] == data_addr[31:2]);
  assign inst_elig = inst_req && slot_free && !inst_full;
  assign data_elig = data_req && slot_free && !data_full && !raw_hit;
  assign starved   = (starve_cnt >= SW'(STARVE_LIM));
  assign inst_gnt  = inst_elig && (!data_elig || starved);
  assign data_gnt  = data_elig && !inst_gnt;

  assign inst_addr_ok = inst_gnt && !reset;
  assign data_addr_ok = data_gnt && !reset;

  always_comb begin
    ar_next = '{id: DATA_ID, addr: data_addr, size: axi_size(data_size)};
    if (inst_gnt) begin
      ar_next = '{id: INST_ID, addr: inst_addr, size: axi_size(inst_size)};
    end
  end

  // The slot reloads in the same cycle as the previous handshake, keeping arvalid high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      arvalid <= 1'b0;
      ar_q    <= '0;
    end else if (inst_gnt || data_gnt) begin
      arvalid <= 1'b1;
      ar_q    <= ar_next;
    end else if (arready) begin
      arvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (inst_gnt || !inst_req) begin
      starve_cnt <= '0;
    end else if (inst_elig && data_gnt && !starved) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end

  assign arid    = ar_q.id;
  assign araddr  = ar_q.addr;
  assign arsize  = ar_q.size;
  assign arlen   = AXI_LEN_SINGLE;
  assign arburst = AXI_BURST_INCR;
  assign arlock  = AXI_LOCK_NORM;
  assign arcache = AXI_CACHE_NONE;
  assign arprot  = AXI_PROT_NONE;

  assign rready   = 1'b1;
  assign inst_hit = rvalid && (rid == INST_ID);
  assign data_hit = rvalid && (rid == DATA_ID);

  assign inst_data_ok = inst_hit && !reset;
  assign data_data_ok = data_hit && !reset;
  assign inst_rdata   = rdata;
  assign data_rdata   = rdata;

  rd_outstanding_cnt #(.MAX(MAX_OUTSTANDING)) u_inst_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (inst_gnt),
    .dec   (inst_hit),
    .cnt   (inst_cnt),
    .full  (inst_full),
    .empty (inst_empty)
  );

  rd_outstanding_cnt #(.MAX(MAX_OUTSTANDING)) u_data_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (data_gnt),
    .dec   (data_hit),
    .cnt   (data_cnt),
    .full  (data_full),
    .empty (data_empty)
  );

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Scoreboard bench for axi_rd_arbiter: expected AR and R records are queued as
// stimulus is driven and retired by a negedge monitor.
module tb_axi_rd_arbiter;
  import axi_rd_arbiter_pkg::*;

  localparam logic [3:0] INST_ID = 4'd0;
  localparam logic [3:0] DATA_ID = 4'd1;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
  } r_exp_t;

  logic        clk;
  logic        reset;
  logic        inst_req, data_req;
  logic [1:0]  inst_size, data_size;
  logic [31:0] inst_addr, data_addr;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        wr_busy;
  logic [31:0] wr_addr;
  logic [3:0]  arid, arlen, arcache;
  logic [31:0] araddr;
  logic [2:0]  arsize, arprot;
  logic [1:0]  arburst, arlock;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic        rvalid, rready;

  ar_req_t exp_ar[$];
  r_exp_t  exp_r[$];
  ar_req_t mon_ar;
  r_exp_t  mon_r;
  int      n_chk = 0;
  int      n_pass = 0;

  axi_rd_arbiter dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_size(data_size), .data_addr(data_addr),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .wr_busy(wr_busy), .wr_addr(wr_addr),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic push_ar(input logic [3:0] id, input logic [31:0] addr, input logic [1:0] size);
    exp_ar.push_back('{id: id, addr: addr, size: {1'b0, size}});
  endtask

  task automatic beat(input logic [3:0] id, input logic [31:0] d);
    rvalid = 1'b1;
    rid    = id;
    rdata  = d;
    if (id == INST_ID || id == DATA_ID) exp_r.push_back('{id: id, data: d});
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (arvalid && arready) begin
        chk("ar_expected", exp_ar.size() != 0, 1'b1);
        if (exp_ar.size() != 0) begin
          mon_ar = exp_ar.pop_front();
          chk("arid", arid, mon_ar.id);
          chk("araddr", araddr, mon_ar.addr);
          chk("arsize", arsize, mon_ar.size);
        end
      end
      if (inst_data_ok || data_data_ok) begin
        chk("r_expected", exp_r.size() != 0, 1'b1);
        if (exp_r.size() != 0) begin
          mon_r = exp_r.pop_front();
          chk("r_route_inst", inst_data_ok, mon_r.id == INST_ID);
          chk("r_route_data", data_data_ok, mon_r.id == DATA_ID);
          chk("rdata", inst_data_ok ? inst_rdata : data_rdata, mon_r.data);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic exp_inst;
    logic exp_ok;

    reset = 1'b1;
    inst_req = 1'b1; inst_size = 2'd2; inst_addr = 32'h0;
    data_req = 1'b1; data_size = 2'd2; data_addr = 32'h0;
    wr_busy = 1'b0; wr_addr = 32'h0;
    arready = 1'b1; rvalid = 1'b1; rid = INST_ID; rdata = 32'h0;

    // reset state
    samp();
    chk("rst_arvalid", arvalid, 1'b0);
    chk("rst_arid", arid, 4'd0);
    chk("rst_araddr", araddr, 32'h0);
    chk("rst_arsize", arsize, 3'd0);
    chk("rst_inst_addr_ok", inst_addr_ok, 1'b0);
    chk("rst_data_addr_ok", data_addr_ok, 1'b0);
    chk("rst_inst_data_ok", inst_data_ok, 1'b0);
    chk("rst_inst_cnt", dut.inst_cnt, 2'd0);
    chk("rst_data_cnt", dut.data_cnt, 2'd0);
    chk("rready", rready, 1'b1);
    chk("arlen", arlen, 4'd0);
    chk("arburst", arburst, 2'b01);
    chk("arlock_cache_prot", {arlock, arcache, arprot}, 9'd0);

    step(); reset = 1'b0; inst_req = 1'b0; data_req = 1'b0; rvalid = 1'b0;
    samp();

    // single inst read
    step(); inst_req = 1'b1; inst_addr = 32'hBFC0_0000; inst_size = 2'd2;
    push_ar(INST_ID, inst_addr, inst_size);
    samp(); chk("t1_inst_addr_ok", inst_addr_ok, 1'b1);
    step(); inst_req = 1'b0;
    samp(); chk("t1_arvalid", arvalid, 1'b1); chk("t1_inst_cnt", dut.inst_cnt, 2'd1);
    step(); beat(INST_ID, 32'h3C1D_0001);
    samp(); chk("t1_inst_data_ok", inst_data_ok, 1'b1);
    step(); rvalid = 1'b0;
    samp(); chk("t1_inst_cnt_back", dut.inst_cnt, 2'd0);

    // starvation relief: data beats keep the data counter from capping
    for (int c = 0; c < 6; c++) begin
      step();
      inst_req = 1'b1; inst_addr = 32'h0000_1000 + 32'(c * 4);
      data_req = 1'b1; data_addr = 32'h0000_2000 + 32'(c * 4);
      rvalid = 1'b0;
      if (c >= 1 && c <= 4) beat(DATA_ID, 32'hA000_0000 + 32'(c));
      exp_inst = (c == 4);
      if (exp_inst) push_ar(INST_ID, inst_addr, inst_size);
      else push_ar(DATA_ID, data_addr, data_size);
      samp();
      chk($sformatf("t2_inst_ok_c%0d", c), inst_addr_ok, exp_inst);
      chk($sformatf("t2_data_ok_c%0d", c), data_addr_ok, !exp_inst);
    end
    step(); inst_req = 1'b0; data_req = 1'b0; rvalid = 1'b0;
    samp(); chk("t2_inst_cnt", dut.inst_cnt, 2'd1); chk("t2_data_cnt", dut.data_cnt, 2'd1);
    step(); beat(INST_ID, 32'h1111_0001);
    step(); beat(DATA_ID, 32'h2222_0001);
    step(); rvalid = 1'b0;
    samp(); chk("t2_drain_inst", dut.inst_cnt, 2'd0); chk("t2_drain_data", dut.data_cnt, 2'd0);

    // outstanding cap on data
    for (int c = 0; c < 6; c++) begin
      step();
      data_req = 1'b1; data_addr = 32'h0000_3000 + 32'(c * 4);
      rvalid = 1'b0;
      if (c == 4) beat(DATA_ID, 32'hCAFE_0004);
      exp_ok = (c < 2) || (c == 5);
      if (exp_ok) push_ar(DATA_ID, data_addr, data_size);
      samp();
      chk($sformatf("t2_cap_ok_c%0d", c), data_addr_ok, exp_ok);
    end
    step(); data_req = 1'b0; rvalid = 1'b0;
    samp(); chk("t2_cap_cnt", dut.data_cnt, 2'd2);
    step(); beat(DATA_ID, 32'hCAFE_0005);
    step(); beat(DATA_ID, 32'hCAFE_0006);
    step(); rvalid = 1'b0;

    // read-after-write blocking
    step();
    wr_busy = 1'b1; wr_addr = 32'h1FC0_0104;
    data_req = 1'b1; data_addr = 32'h1FC0_0106; data_size = 2'd1;
    inst_req = 1'b1; inst_addr = 32'hBFC0_0010; inst_size = 2'd2;
    push_ar(INST_ID, inst_addr, inst_size);
    samp(); chk("t3_data_blocked", data_addr_ok, 1'b0); chk("t3_inst_ok", inst_addr_ok, 1'b1);
    step(); inst_req = 1'b0;
    samp(); chk("t3_data_still_blocked", data_addr_ok, 1'b0);
    step(); wr_busy = 1'b0;
    push_ar(DATA_ID, data_addr, data_size);
    samp(); chk("t3_data_released", data_addr_ok, 1'b1);
    step(); wr_busy = 1'b1; wr_addr = 32'h1FC0_0108; data_addr = 32'h1FC0_0100; data_size = 2'd2;
    push_ar(DATA_ID, data_addr, data_size);
    samp(); chk("t3_other_word_ok", data_addr_ok, 1'b1);
    step(); data_req = 1'b0; wr_busy = 1'b0;
    samp();
    step(); beat(INST_ID, 32'h3333_0001);
    step(); beat(DATA_ID, 32'h3333_0002);
    step(); beat(DATA_ID, 32'h3333_0003);
    step(); rvalid = 1'b0;
    samp(); chk("t3_inst_cnt", dut.inst_cnt, 2'd0); chk("t3_data_cnt", dut.data_cnt, 2'd0);

    // AR backpressure and back-to-back reload
    step(); arready = 1'b0; inst_req = 1'b1; inst_addr = 32'h0000_4000;
    push_ar(INST_ID, inst_addr, inst_size);
    samp(); chk("t4_first_ok", inst_addr_ok, 1'b1);
    for (int c = 0; c < 3; c++) begin
      step(); inst_addr = 32'h0000_5000;
      samp();
      chk($sformatf("t4_no_ok_c%0d", c), inst_addr_ok, 1'b0);
      chk($sformatf("t4_arvalid_c%0d", c), arvalid, 1'b1);
      chk($sformatf("t4_araddr_c%0d", c), araddr, 32'h0000_4000);
      chk($sformatf("t4_arid_c%0d", c), arid, INST_ID);
    end
    step(); arready = 1'b1;
    push_ar(INST_ID, inst_addr, inst_size);
    samp(); chk("t4_reload_ok", inst_addr_ok, 1'b1);
    step(); inst_req = 1'b0;
    samp(); chk("t4_b2b_arvalid", arvalid, 1'b1);
    step();
    samp(); chk("t4_idle_arvalid", arvalid, 1'b0);
    step(); beat(INST_ID, 32'h4444_0001);
    step(); beat(INST_ID, 32'h4444_0002);
    step(); rvalid = 1'b0;

    // out-of-order IDs, unknown rid, simultaneous inc/dec
    step(); inst_req = 1'b1; inst_addr = 32'h0000_0100;
    push_ar(INST_ID, inst_addr, inst_size);
    samp(); chk("t5_inst_ok", inst_addr_ok, 1'b1);
    step(); inst_req = 1'b0; data_req = 1'b1; data_addr = 32'h0000_0200;
    push_ar(DATA_ID, data_addr, data_size);
    samp(); chk("t5_data_ok", data_addr_ok, 1'b1);
    step(); data_req = 1'b0;
    samp();
    step(); beat(DATA_ID, 32'hD000_0001);
    samp(); chk("t5_data_first", data_data_ok, 1'b1); chk("t5_inst_not_yet", inst_data_ok, 1'b0);
    step(); beat(INST_ID, 32'h1000_0001);
    samp(); chk("t5_inst_second", inst_data_ok, 1'b1);
    step(); beat(4'd5, 32'hDEAD_BEEF);
    samp();
    chk("t5_stray_inst", inst_data_ok, 1'b0); chk("t5_stray_data", data_data_ok, 1'b0);
    chk("t5_inst_cnt", dut.inst_cnt, 2'd0); chk("t5_data_cnt", dut.data_cnt, 2'd0);
    step(); rvalid = 1'b0; data_req = 1'b1; data_addr = 32'h0000_0300;
    push_ar(DATA_ID, data_addr, data_size);
    samp();
    step(); beat(DATA_ID, 32'hD000_0002); data_addr = 32'h0000_0304;
    push_ar(DATA_ID, data_addr, data_size);
    samp(); chk("t5_simul_grant", data_addr_ok, 1'b1);
    step(); data_req = 1'b0; rvalid = 1'b0;
    samp(); chk("t5_simul_cnt", dut.data_cnt, 2'd1);
    step(); beat(DATA_ID, 32'hD000_0003);
    step(); rvalid = 1'b0;
    samp(); chk("t5_final_cnt", dut.data_cnt, 2'd0);

    // reset mid-transaction
    step(); arready = 1'b1;
    inst_req = 1'b1; inst_addr = 32'h0000_0600;
    data_req = 1'b1; data_addr = 32'h0000_0700;
    push_ar(DATA_ID, data_addr, data_size);
    samp(); chk("t6_g0_data", data_addr_ok, 1'b1);
    step(); push_ar(DATA_ID, data_addr, data_size);
    samp(); chk("t6_g1_data", data_addr_ok, 1'b1);
    step(); push_ar(INST_ID, inst_addr, inst_size);
    samp(); chk("t6_g2_inst", inst_addr_ok, 1'b1);
    step();
    samp(); chk("t6_g3_inst", inst_addr_ok, 1'b1);
    step(); arready = 1'b0;
    samp();
    chk("t6_full_inst", dut.inst_cnt, 2'd2); chk("t6_full_data", dut.data_cnt, 2'd2);
    chk("t6_arvalid", arvalid, 1'b1);
    chk("t6_no_inst_ok", inst_addr_ok, 1'b0); chk("t6_no_data_ok", data_addr_ok, 1'b0);
    step(); reset = 1'b1; rvalid = 1'b1; rid = INST_ID; rdata = 32'h5555_5555;
    samp();
    chk("t6_rst_arvalid", arvalid, 1'b0);
    chk("t6_rst_inst_cnt", dut.inst_cnt, 2'd0); chk("t6_rst_data_cnt", dut.data_cnt, 2'd0);
    chk("t6_rst_inst_ok", inst_addr_ok, 1'b0); chk("t6_rst_data_ok", data_addr_ok, 1'b0);
    chk("t6_rst_data_ok_r", inst_data_ok, 1'b0);
    step(); reset = 1'b0; inst_req = 1'b0; data_req = 1'b0; rvalid = 1'b0; arready = 1'b1;
    samp(); chk("t6_post_arvalid", arvalid, 1'b0);
    step(); inst_req = 1'b1; inst_addr = 32'hBFC0_0000;
    push_ar(INST_ID, inst_addr, inst_size);
    samp(); chk("t6_fresh_ok", inst_addr_ok, 1'b1);
    step(); inst_req = 1'b0;
    samp(); chk("t6_fresh_arvalid", arvalid, 1'b1);
    step(); beat(INST_ID, 32'h6666_0001);
    samp();
    step(); beat(DATA_ID, 32'h6666_0002);
    samp(); chk("t6_stray_beat_ok", data_data_ok, 1'b1);
    step(); rvalid = 1'b0;
    samp(); chk("t6_end_inst", dut.inst_cnt, 2'd0); chk("t6_end_data", dut.data_cnt, 2'd0);

    chk("ar_drained", exp_ar.size(), 0);
    chk("r_drained", exp_r.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
